gb80_oam_dma: RTL and testbench
===============================

GB80_OAM_DMA -- requirements
Module: gb80_oam_dma

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bus width.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 Parameter XFER_LEN, default 160, bytes per transfer.
REQ-004 Parameter DEST_BASE, default 16'hFE00, OAM destination base address.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_reset  input  1  reset, asynchronous, active-low.
REQ-007 i_start  input  1  one-cycle start pulse (write to DMA register).
REQ-008 i_src_page  input  8  source high byte, sampled with i_start.
REQ-009 i_cpu_rd  input  1  CPU read request.
REQ-010 i_cpu_wr  input  1  CPU write request.
REQ-011 i_cpu_addr  input  16  CPU address.
REQ-012 i_cpu_data  input  8  CPU write data.
REQ-013 o_cpu_data  output  8  CPU read data.
REQ-014 o_cpu_wait  output  1  CPU request refused this cycle.
REQ-015 o_memory_rd / o_memory_wr  output  1 each  memory strobes.
REQ-016 o_memory_addr  output  16  memory address.
REQ-017 o_memory_data  output  8  memory write data.
REQ-018 i_memory_data  input  8  memory read data, valid same cycle as o_memory_rd.
REQ-019 o_busy  output  1  transfer in progress.
REQ-020 o_done  output  1  one-cycle completion pulse.

Function
REQ-021 States: IDLE, SETUP, READ, WRITE, DONE.
REQ-022 IDLE: memory port is a combinational passthrough of CPU port; o_cpu_wait=0; o_cpu_data=i_memory_data.
REQ-023 i_start high at an edge in any state -> SETUP next cycle; page latched; byte index cleared to 0.
REQ-024 Cycle N = first cycle with o_busy=1 (SETUP): no memory strobes.
REQ-025 Cycle N+1+2k (READ): o_memory_rd=1, addr {page, k[7:0]}; i_memory_data captured into holding register at cycle end.
REQ-026 Cycle N+2+2k (WRITE): o_memory_wr=1, addr DEST_BASE+k, o_memory_data=holding register; index increments.
REQ-027 After WRITE with k=XFER_LEN-1 -> DONE (cycle N+2*XFER_LEN+1): o_done=1, o_busy=0, no strobes; then IDLE.
REQ-028 o_busy=1 in SETUP, READ, WRITE only; total busy time 2*XFER_LEN+1 cycles.
REQ-029 While busy: any CPU request -> o_cpu_wait=1, no CPU strobe reaches memory, o_cpu_data=8'hFF.
REQ-030 While busy without CPU request: o_cpu_wait=0, o_cpu_data=8'hFF.
REQ-031 Restart: i_start during SETUP/READ/WRITE/DONE aborts current transfer, no o_done pulse for it, restarts at k=0 with new page.
REQ-032 Index counter 8 bits; never exceeds XFER_LEN-1; no wrap within a transfer.
REQ-033 Source low byte equals k; page value used unmodified (no remapping).
REQ-034 o_memory_rd and o_memory_wr never both 1 in the same cycle.

Reset
REQ-035 i_reset low asynchronously forces IDLE, index 0, page 0, holding register 0.
REQ-036 During and after reset: o_busy=0, o_done=0, o_cpu_wait=0, memory port in passthrough.
REQ-037 Reset mid-transfer abandons it; no o_done; OAM bytes already written stay written.

Structure
REQ-038 Shared package gb80_pkg holds state encoding, DEST_BASE and XFER_LEN defaults, address width constants.
REQ-039 Holding register is one instance of existing sub-module register (DATA_WIDTH 8), write-enabled in READ.
REQ-040 FSM, index counter and port mux reside in gb80_oam_dma.

Verification
REQ-041 i_start with page 8'hC1, memory C100..C19F = k^8'h5A -> FE00..FE9F match, o_done at cycle N+321, o_busy low at N+321.
REQ-042 CPU read of 16'hC000 at N+50 -> o_cpu_wait=1, o_cpu_data=8'hFF, no CPU strobe; same read in IDLE -> passthrough data, wait=0.
REQ-043 i_start page 8'hC1, second i_start page 8'hD0 at N+100 -> final OAM = D000..D09F, exactly one o_done.
REQ-044 i_reset low at N+77 -> o_busy=0 immediately, no o_done, no strobes until next i_start.
REQ-045 Every cycle of a transfer: rd and wr never both 1; write addresses strictly FE00..FE9F ascending.
REQ-046 i_start with page 8'hFF -> reads FF00..FF9F, no address remap.

Source files
------------

// File: rtl/gb80_pkg.sv
// Shared constants and state encoding for the GB80 OAM DMA engine.
package gb80_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } dma_state_t;

   localparam int          GB_DATA_WIDTH = 8;
   localparam int          GB_ADDR_WIDTH = 16;
   localparam int          OAM_XFER_LEN  = 160;
   localparam logic [15:0] OAM_DEST_BASE = 16'hFE00;

endpackage

// File: rtl/register.sv
// Enable-gated data register with asynchronous active-low clear.
module register #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);

   // Capture data when enabled
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_q <= {DATA_WIDTH{1'b0}};
      end else if (i_en) begin
         o_q <= i_d;
      end else begin
         o_q <= o_q;
      end
   end

endmodule

// File: rtl/gb80_oam_dma.sv
// OAM DMA: copies XFER_LEN bytes from {page, k} to DEST_BASE+k, one read and
// one write cycle per byte, locking the CPU off the memory port while busy.
module gb80_oam_dma
   import gb80_pkg::*;
#(
   parameter int                    DATA_WIDTH = GB_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = GB_ADDR_WIDTH,
   parameter int                    XFER_LEN   = OAM_XFER_LEN,
   parameter logic [ADDR_WIDTH-1:0] DEST_BASE  = ADDR_WIDTH'(OAM_DEST_BASE)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [7:0]            i_src_page,
   input  logic                  i_cpu_rd,
   input  logic                  i_cpu_wr,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [DATA_WIDTH-1:0] i_cpu_data,
   output logic [DATA_WIDTH-1:0] o_cpu_data,
   output logic                  o_cpu_wait,
   output logic                  o_memory_rd,
   output logic                  o_memory_wr,
   output logic [ADDR_WIDTH-1:0] o_memory_addr,
   output logic [DATA_WIDTH-1:0] o_memory_data,
   input  logic [DATA_WIDTH-1:0] i_memory_data,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t            state_r;
   logic [7:0]            page_r;
   logic [7:0]            idx_r;
   logic                  busy_r;
   logic                  done_r;
   logic [DATA_WIDTH-1:0] hold_q_s;
   logic                  hold_en_s;
   logic                  cpu_req_s;

   assign hold_en_s = (state_r == ST_READ);
   assign cpu_req_s = i_cpu_rd | i_cpu_wr;
   assign o_busy    = busy_r;
   assign o_done    = done_r;

   register #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (hold_en_s),
      .i_d     (i_memory_data),
      .o_q     (hold_q_s)
   );

   // Transfer sequencer; a start pulse overrides whatever is in flight
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r <= ST_IDLE;
         page_r  <= 8'h00;
         idx_r   <= 8'h00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (i_start) begin
         state_r <= ST_SETUP;
         page_r  <= i_src_page;
         idx_r   <= 8'h00;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_SETUP: begin
               state_r <= ST_READ;
               busy_r  <= 1'b1;
               done_r  <= 1'b0;
            end
            ST_READ: begin
               state_r <= ST_WRITE;
               busy_r  <= 1'b1;
               done_r  <= 1'b0;
            end
            ST_WRITE: begin
               if (idx_r == LAST_IDX) begin
                  state_r <= ST_DONE;
                  idx_r   <= 8'h00;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= ST_READ;
                  idx_r   <= idx_r + 8'd1;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            ST_IDLE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= 8'h00;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Memory port owner select: CPU passthrough when idle, DMA otherwise
   always_comb begin
      o_memory_rd   = 1'b0;
      o_memory_wr   = 1'b0;
      o_memory_addr = {ADDR_WIDTH{1'b0}};
      o_memory_data = {DATA_WIDTH{1'b0}};
      o_cpu_data    = {DATA_WIDTH{1'b1}};
      o_cpu_wait    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            o_memory_rd   = i_cpu_rd;
            o_memory_wr   = i_cpu_wr;
            o_memory_addr = i_cpu_addr;
            o_memory_data = i_cpu_data;
            o_cpu_data    = i_memory_data;
         end
         ST_READ: begin
            o_memory_rd   = 1'b1;
            o_memory_addr = ADDR_WIDTH'({page_r, idx_r});
            o_cpu_wait    = cpu_req_s;
         end
         ST_WRITE: begin
            o_memory_wr   = 1'b1;
            o_memory_addr = DEST_BASE + ADDR_WIDTH'(idx_r);
            o_memory_data = hold_q_s;
            o_cpu_wait    = cpu_req_s;
         end
         ST_SETUP, ST_DONE: begin
            o_cpu_wait = cpu_req_s;
         end
         default: begin
            o_cpu_wait = cpu_req_s;
         end
      endcase
   end

endmodule

// File: tb/tb_gb80_oam_dma.sv
// Directed bench for gb80_oam_dma: idle passthrough vectors plus full,
// restarted, reset-aborted and high-page transfers against a memory model.
module tb_gb80_oam_dma;

   localparam int L = 160;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  page;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:65535];
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   int          seq_err  = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  mem_val;
      logic [34:0] exp;
   } vec_t;

   vec_t vecs [4];

   assign mem_rdata = mem[mem_addr];

   always #5 clk = ~clk;

   gb80_oam_dma dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_start       (start),
      .i_src_page    (page),
      .i_cpu_rd      (cpu_rd),
      .i_cpu_wr      (cpu_wr),
      .i_cpu_addr    (cpu_addr),
      .i_cpu_data    (cpu_wdata),
      .o_cpu_data    (cpu_rdata),
      .o_cpu_wait    (cpu_wait),
      .o_memory_rd   (mem_rd),
      .o_memory_wr   (mem_wr),
      .o_memory_addr (mem_addr),
      .o_memory_data (mem_wdata),
      .i_memory_data (mem_rdata),
      .o_busy        (busy),
      .o_done        (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory writes and done pulses are taken mid-cycle, then step to just after the next edge
   task automatic tick();
      @(negedge clk);
      if (mem_wr === 1'b1) mem[mem_addr] = mem_wdata;
      if (done === 1'b1) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [7:0] pg);
      page  = pg;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Checks cycles N+j0..N+j1 of a transfer against the expected strobe schedule
   task automatic run_span(input logic [7:0] pg, input int j0, input int j1);
      for (int j = j0; j <= j1; j++) begin
         logic        erd;
         logic        ewr;
         logic [15:0] ea;
         erd = (j >= 1) && (j <= 2*L) && (j % 2 == 1);
         ewr = (j >= 2) && (j <= 2*L) && (j % 2 == 0);
         ea  = erd ? {pg, 8'((j - 1) / 2)} : (16'hFE00 + 16'((j - 2) / 2));
         if (mem_rd !== erd || mem_wr !== ewr || busy !== (j <= 2*L) ||
             done !== (j == 2*L + 1) || ((erd || ewr) && mem_addr !== ea))
            seq_err++;
         tick();
      end
   endtask

   task automatic preload(input logic [7:0] pg, input logic [7:0] key);
      for (int k = 0; k < L; k++) mem[{pg, 8'(k)}] = 8'(k) ^ key;
      for (int k = 0; k < L; k++) mem[16'hFE00 + 16'(k)] = 8'h00;
   endtask

   task automatic check_oam(input string name, input logic [7:0] key, input int nwritten);
      int errs = 0;
      for (int k = 0; k < L; k++) begin
         logic [7:0] e;
         e = (k < nwritten) ? (8'(k) ^ key) : 8'h00;
         if (mem[16'hFE00 + 16'(k)] !== e) errs++;
      end
      check(name, 64'(errs), 64'd0);
   endtask

   initial begin
      int strobes;
      vecs[0] = '{1'b1, 1'b0, 16'hC000, 8'h00, 8'h3C, {1'b1, 1'b0, 16'hC000, 8'h00, 8'h3C, 1'b0}};
      vecs[1] = '{1'b0, 1'b1, 16'hA123, 8'h5E, 8'h11, {1'b0, 1'b1, 16'hA123, 8'h5E, 8'h11, 1'b0}};
      vecs[2] = '{1'b0, 1'b0, 16'hFE10, 8'h99, 8'h42, {1'b0, 1'b0, 16'hFE10, 8'h99, 8'h42, 1'b0}};
      vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hE7, {1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hE7, 1'b0}};
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

      rst_n = 1'b0; start = 1'b0; page = 8'h00;
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
      mem[16'h1234] = 8'h77;
      #2;
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_done", 64'(done), 64'(1'b0));
      check("rst_wait", 64'(cpu_wait), 64'(1'b0));
      check("rst_passthru", 64'({mem_rd, mem_wr, mem_addr, cpu_rdata}), 64'({1'b1, 1'b0, 16'h1234, 8'h77}));
      tick();
      rst_n = 1'b1; cpu_rd = 1'b0;
      tick();

      // Idle passthrough table
      for (int i = 0; i < 4; i++) begin
         mem[vecs[i].addr] = vecs[i].mem_val;
         cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr;
         cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
         #1;
         check($sformatf("idle_vec%0d", i),
               64'({mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rdata, cpu_wait}), 64'(vecs[i].exp));
         tick();
         cpu_rd = 1'b0; cpu_wr = 1'b0;
      end
      mem[16'hC000] = 8'h3C;

      // Full transfer from page C1 with a refused CPU read at N+50
      preload(8'hC1, 8'h5A);
      done_cnt = 0; seq_err = 0;
      start_xfer(8'hC1);
      check("busy_at_N", 64'({busy, mem_rd, mem_wr}), 64'({1'b1, 1'b0, 1'b0}));
      run_span(8'hC1, 0, 49);
      cpu_rd = 1'b1; cpu_addr = 16'hC000;
      #1;
      check("busy_cpu_wait", 64'(cpu_wait), 64'(1'b1));
      check("busy_cpu_data", 64'(cpu_rdata), 64'(8'hFF));
      check("busy_no_cpu_strobe", 64'({mem_rd, mem_wr, mem_addr}), 64'({1'b0, 1'b1, 16'hFE18}));
      run_span(8'hC1, 50, 50);
      cpu_rd = 1'b0;
      #1;
      check("busy_noreq", 64'({cpu_wait, cpu_rdata}), 64'({1'b0, 8'hFF}));
      run_span(8'hC1, 51, 320);
      check("done_at_N321", 64'({done, busy}), 64'({1'b1, 1'b0}));
      run_span(8'hC1, 321, 321);
      check("after_done", 64'({done, busy}), 64'({1'b0, 1'b0}));
      check("seq_c1", 64'(seq_err), 64'd0);
      check("done_cnt_c1", 64'(done_cnt), 64'd1);
      check_oam("oam_c1", 8'h5A, L);
      cpu_rd = 1'b1; cpu_addr = 16'hC000;
      #1;
      check("idle_read_c000", 64'({cpu_wait, cpu_rdata, mem_rd}), 64'({1'b0, 8'h3C, 1'b1}));
      cpu_rd = 1'b0;
      tick();

      // Restart from page D0 at N+100
      preload(8'hD0, 8'hA5);
      for (int k = 0; k < L; k++) mem[16'hC100 + 16'(k)] = 8'(k) ^ 8'h5A;
      done_cnt = 0; seq_err = 0;
      start_xfer(8'hC1);
      run_span(8'hC1, 0, 99);
      start = 1'b1; page = 8'hD0;
      run_span(8'hC1, 100, 100);
      start = 1'b0;
      run_span(8'hD0, 0, 2*L + 1);
      tick(); tick();
      check("seq_restart", 64'(seq_err), 64'd0);
      check("done_cnt_restart", 64'(done_cnt), 64'd1);
      check_oam("oam_d0", 8'hA5, L);

      // Reset at N+77 abandons the transfer
      preload(8'hC1, 8'h5A);
      done_cnt = 0; seq_err = 0;
      start_xfer(8'hC1);
      run_span(8'hC1, 0, 76);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'({busy, done, mem_rd, mem_wr}), 64'(4'b0000));
      tick();
      rst_n = 1'b1;
      strobes = 0;
      for (int c = 0; c < 400; c++) begin
         if (mem_rd === 1'b1 || mem_wr === 1'b1 || busy === 1'b1) strobes++;
         tick();
      end
      check("rst_no_activity", 64'(strobes), 64'd0);
      check("rst_no_done", 64'(done_cnt), 64'd0);
      check("seq_pre_reset", 64'(seq_err), 64'd0);
      check_oam("oam_partial", 8'h5A, 38);

      // Page FF is used as-is
      preload(8'hFF, 8'h33);
      done_cnt = 0; seq_err = 0;
      start_xfer(8'hFF);
      run_span(8'hFF, 0, 2*L + 1);
      check("seq_ff", 64'(seq_err), 64'd0);
      check("done_cnt_ff", 64'(done_cnt), 64'd1);
      check_oam("oam_ff", 8'h33, L);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
